// File: rtl/trig_ctrl_pkg.sv
// trig_ctrl_pkg: shared state encodings, trigger mode/source codes and width defaults
package trig_ctrl_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam logic [2:0] M_RISE  = 3'd0;
  localparam logic [2:0] M_FALL  = 3'd1;
  localparam logic [2:0] M_HI_GT = 3'd2;
  localparam logic [2:0] M_HI_LT = 3'd3;
  localparam logic [2:0] M_LO_GT = 3'd4;
  localparam logic [2:0] M_LO_LT = 3'd5;
  localparam logic [2:0] M_AUTO  = 3'd6;
  localparam logic [2:0] M_FORCE = 3'd7;
  localparam logic [1:0] S_A = 2'd0;
  localparam logic [1:0] S_B = 2'd1;
  localparam logic [1:0] S_C = 2'd2;
  localparam logic [1:0] S_D = 2'd3;
endpackage

// File: rtl/trig_cmp.sv
// trig_cmp: source mux, saturating hysteresis comparator, level register and pulse-width counter
//   in : Wclk, Reset, Sample_En, A/B/CD samples, Trig_Src, Trig_Mode, Vt, Sens, Width
//   out: rise/fall (level edges on this sample), pulse_q (pulse-width mode qualified on this sample)
module trig_cmp import trig_ctrl_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Wclk,
  input  logic             Reset,
  input  logic             Sample_En,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [1:0]       CD,
  input  logic [1:0]       Trig_Src,
  input  logic [2:0]       Trig_Mode,
  input  logic [7:0]       Vt,
  input  logic [7:0]       Sens,
  input  logic [CNT_W-1:0] Width,
  output logic             rise,
  output logic             fall,
  output logic             pulse_q
);
  logic [1:0] src_q;
  logic [CNT_W-1:0] cnt;
  logic [8:0] sum, dif;
  logic [7:0] smp, hi, lo;
  logic lvl, lvl_n, reload, chg;
  // Flags are combinational on the sample cycle so the controller registers the trigger one clock later.
  always_comb begin
    smp = Trig_Src == S_B ? B : A;
    sum = {1'b0, Vt} + {1'b0, Sens};
    dif = {1'b0, Vt} - {1'b0, Sens};
    hi = sum[8] ? 8'hff : sum[7:0];
    lo = dif[8] ? 8'h00 : dif[7:0];
    lvl_n = Trig_Src == S_C ? CD[0] : Trig_Src == S_D ? CD[1] : smp >= hi ? 1'b1 : smp <= lo ? 1'b0 : lvl;
    reload = Trig_Src != src_q;
    chg = Sample_En && !reload && lvl_n != lvl;
    rise = chg && lvl_n;
    fall = chg && !lvl_n;
    pulse_q = Trig_Mode == M_HI_GT ? fall && cnt > Width :
              Trig_Mode == M_HI_LT ? fall && cnt < Width :
              Trig_Mode == M_LO_GT ? rise && cnt > Width :
              Trig_Mode == M_LO_LT ? rise && cnt < Width : 1'b0;
  end
  // A source switch reloads the level silently and restarts the run length.
  always_ff @(posedge Wclk) begin
    if (Reset) begin
      lvl <= 1'b0;
      cnt <= '0;
      src_q <= S_A;
    end else if (Sample_En) begin
      lvl <= lvl_n;
      src_q <= Trig_Src;
      cnt <= (reload || lvl_n != lvl) ? CNT_W'(1) : &cnt ? cnt : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/trig_ctrl.sv
// trig_ctrl: trigger detector and capture sequencer filling the sample memory around a trigger
//   in : Wclk, Reset, Sample_En, A/B/CD samples, Arm/Force pulses, Trig_Src, Trig_Mode, Vt, Sens, Width, Pre_Depth
//   out: Waddr/Wr_En memory write port, Trig_Addr, Trigged, Full, State status
module trig_ctrl import trig_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              Wclk,
  input  logic              Reset,
  input  logic              Sample_En,
  input  logic [7:0]        A,
  input  logic [7:0]        B,
  input  logic [1:0]        CD,
  input  logic              Arm,
  input  logic              Force,
  input  logic [1:0]        Trig_Src,
  input  logic [2:0]        Trig_Mode,
  input  logic [7:0]        Vt,
  input  logic [7:0]        Sens,
  input  logic [CNT_W-1:0]  Width,
  input  logic [ADDR_W-1:0] Pre_Depth,
  output logic [ADDR_W-1:0] Waddr,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Trig_Addr,
  output logic              Trigged,
  output logic              Full,
  output logic [2:0]        State
);
  state_t st, st_n;
  logic [ADDR_W:0] cnt, cnt_inc, post_len;
  logic force_pend, frc, act, qual, hit, rise, fall, pulse_q;
  trig_cmp #(.CNT_W(CNT_W)) u_cmp (
    .Wclk(Wclk),
    .Reset(Reset),
    .Sample_En(Sample_En),
    .A(A),
    .B(B),
    .CD(CD),
    .Trig_Src(Trig_Src),
    .Trig_Mode(Trig_Mode),
    .Vt(Vt),
    .Sens(Sens),
    .Width(Width),
    .rise(rise),
    .fall(fall),
    .pulse_q(pulse_q)
  );
  // cnt counts pre-trigger samples in PRE and post-trigger samples (trigger included) in POST.
  always_comb begin
    act = st == PRE || st == ARMED;
    Wr_En = Sample_En && (act || st == POST);
    frc = Force || force_pend;
    cnt_inc = cnt + (ADDR_W+1)'(1);
    post_len = {1'b1, {ADDR_W{1'b0}}} - {1'b0, Pre_Depth};
    qual = Trig_Mode == M_RISE ? rise : Trig_Mode == M_FALL ? fall : Trig_Mode == M_AUTO ? 1'b1 : pulse_q;
    hit = Sample_En && ((frc && act) || (st == ARMED && qual));
    st_n = st;
    if (Arm) st_n = Pre_Depth == '0 ? ARMED : PRE;
    else if (hit) st_n = post_len == (ADDR_W+1)'(1) ? DONE : POST;
    else if (Sample_En && st == PRE && cnt_inc == {1'b0, Pre_Depth}) st_n = ARMED;
    else if (Sample_En && st == POST && cnt_inc == post_len) st_n = DONE;
  end
  assign State = st;
  always_ff @(posedge Wclk) begin
    if (Reset) begin
      st <= IDLE;
      Waddr <= '0;
      Trig_Addr <= '0;
      Trigged <= 1'b0;
      Full <= 1'b0;
      cnt <= '0;
      force_pend <= 1'b0;
    end else begin
      st <= st_n;
      // A Force seen between samples waits for the next sample of an active capture.
      force_pend <= !Arm && frc && !Sample_En && act;
      Full <= !Arm && (Full || st_n == DONE);
      if (Arm) Waddr <= '0;
      else if (Wr_En) Waddr <= Waddr + ADDR_W'(1);
      if (Arm) Trigged <= 1'b0;
      else if (hit) begin
        Trigged <= 1'b1;
        Trig_Addr <= Waddr;
      end
      if (Arm) cnt <= '0;
      else if (hit) cnt <= (ADDR_W+1)'(1);
      else if (Sample_En && st == PRE) cnt <= st_n == ARMED ? '0 : cnt_inc;
      else if (Sample_En && st == POST) cnt <= cnt_inc;
    end
  end
endmodule

// File: doc/trig_ctrl.md
# trig_ctrl

Trigger detector and capture sequencer for the acquisition buffer. It consumes the registered per-sample channel bytes A/B/CD produced by the buffer's input stage. It detects edge or pulse-width trigger events with hysteresis and generates the write address and enable that fill the 4096-deep sample memory, with a programmable pre-trigger depth. It reports the trigger address and buffer-full status to the MCU interface.

## Interface
- ADDR_W, 12: sample memory address width (depth 2^ADDR_W)
- CNT_W, 16: pulse-width counter width
- Wclk  in  1  sample clock, rising edge; all logic in this domain
- Reset  in  1  synchronous, active-high
- Sample_En  in  1  one-cycle strobe per stored sample
- A, B  in  8 each  analog channel bytes, valid on Sample_En
- CD  in  2  digital channels C = CD[0], D = CD[1]
- Arm  in  1  pulse: restart capture
- Force  in  1  pulse: immediate trigger
- Trig_Src  in  2  0 = A, 1 = B, 2 = C, 3 = D
- Trig_Mode  in  3  0 rise, 1 fall, 2 hi-pulse > Width, 3 hi-pulse < Width, 4 lo-pulse > Width, 5 lo-pulse < Width, 6 auto, 7 Force only
- Vt  in  8  threshold; ignored for C/D
- Sens  in  8  hysteresis half-band; ignored for C/D
- Width  in  CNT_W  pulse reference, in samples
- Pre_Depth  in  ADDR_W  samples kept before the trigger
- Waddr  out  ADDR_W  write address to sample memory
- Wr_En  out  1  write strobe (= Sample_En while capturing)
- Trig_Addr  out  ADDR_W  address of the triggering sample
- Trigged  out  1  trigger has occurred this capture
- Full  out  1  capture complete
- State  out  3  FSM state, for status readback

## Operation
- States: IDLE(0), PRE(1), ARMED(2), POST(3), DONE(4).
- Arm, from any state:
  - Waddr ← 0; clear Trigged, Full, and the pre/post counters.
  - Go to PRE, or to ARMED if Pre_Depth = 0.
- PRE:
  - Each Sample_En writes and increments Waddr.
  - After Pre_Depth samples, go to ARMED.
  - Trigger events in PRE are ignored; Force is honoured.
- ARMED:
  - Writing continues, with Waddr wrapping modulo 2^ADDR_W.
  - On a qualifying sample: Trig_Addr ← Waddr of that sample; Trigged ← 1; go to POST.
  - Mode 6 triggers on the first sample in ARMED.
  - Mode 7 triggers only on Force.
- POST:
  - Writes continue until 2^ADDR_W − Pre_Depth samples are written, counting the trigger sample.
  - Then Full ← 1 and go to DONE; Waddr then points to the oldest sample.
- DONE and IDLE: Wr_En = 0 and Waddr holds. Leave only on Arm.
- Hysteresis level Lvl, updated on every Sample_En in all states:
  - Lvl ← 1 if sample ≥ sat(Vt + Sens); Lvl ← 0 if sample ≤ sat(Vt − Sens); otherwise hold.
  - sat clamps the result to 0..255.
  - For C/D, Lvl = the bit itself.
- Edges:
  - rise = Lvl 0→1; fall = Lvl 1→0.
  - Trig_Src change: Lvl is reloaded without generating an edge.
- Pulse counter:
  - Counts samples while Lvl stays constant, saturating at 2^CNT_W − 1.
  - Resets to 1 on each Lvl change.
  - Pulse modes qualify on the edge that ends the pulse, comparing the completed length against Width (strict > or <).
- Simultaneous events:
  - Arm beats Force and triggers in the same cycle.
  - Force together with a qualifying sample produces one trigger.
  - Reset beats everything.

## Timing
- Wr_En and Waddr are combinational from state and the current Waddr register, so the DP memory write uses the address of the current sample.
- Waddr increments on the Wclk edge that ends a Sample_En cycle.
- Trigged, Trig_Addr and the state change are registered one Wclk after the qualifying Sample_En cycle.
- Force takes effect at the next Sample_En, capturing that sample's address.
- Full rises one Wclk after the final write.
- Reset values: State = IDLE, Waddr = 0, Trig_Addr = 0, Trigged = 0, Full = 0, Wr_En = 0, Lvl = 0, pulse counter = 0.
- Reset mid-capture: all of the above on the next edge; no further writes.

## Structure
- Shared package holds:
  - state encodings
  - Trig_Mode and Trig_Src constants
  - ADDR_W/CNT_W defaults
- One sub-module: trig_cmp, which contains:
  - source mux
  - saturating hysteresis comparator
  - Lvl register
  - pulse counter
  - outputs rise/fall/pulse-qualified flags
- The FSM and address counters live in trig_ctrl.

## Test plan
- Rise on A, Vt = 128, Sens = 4, Pre_Depth = 1024:
  - Ramp 100→200 after ARMED; trigger fires at the first sample ≥ 132.
  - Trigged is set and Trig_Addr = that sample's address.
  - Full is set after 3072 samples counted from the trigger.
- Hysteresis, Vt = 128, Sens = 4: input toggles 127↔131 → no trigger. Input 120→140 → one rise.
- Mode 2 on C, Width = 10:
  - High pulses of 8 and 12 samples → trigger only on the falling edge ending the 12-sample pulse.
  - Counter saturates at 65535 under a constant input.
- Pre_Depth = 0, mode 6:
  - Trigger on the first sample after Arm, with Trig_Addr = 0.
  - Waddr wraps 4095→0, and Full is set after 4096 writes.
- Arm during POST restarts with Waddr = 0 and Trigged = 0. Force in mode 7 triggers at the next Sample_En.
- Reset asserted mid-ARMED → State = 0, Wr_En = 0, and Waddr = 0 on the next edge.
